vram_dma_m: RTL and testbench

//   CPU-triggered bulk copy from system RAM into VRAM (OAM/tilemap upload). Sits beside

---
 rtl/vram_dma_pkg.sv | 6 +
 rtl/vram_dma_addr_gen_m.sv | 40 ++++
 rtl/vram_dma_m.sv | 90 +++++++++
 tb/tb_vram_dma_m.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vram_dma_pkg.sv
// vram_dma_pkg: shared state encoding and default addresses for the VRAM DMA engine.
package vram_dma_pkg;
   typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} dma_state_t;
   localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h7010;
   localparam logic [15:0] VRAM_BASE = 16'h3700;
endpackage

// File: rtl/vram_dma_addr_gen_m.sv
// vram_dma_addr_gen_m: byte counter plus source/destination address adders for the copy.
module vram_dma_addr_gen_m import vram_dma_pkg::*; #(
   parameter logic [15:0] DST_BASE = VRAM_BASE,
   parameter int LENGTH = 256,
   localparam int CW = $clog2(LENGTH + 1)
) (
   input  logic        cpu_clk,
   input  logic        rst,
   input  logic        cpu_clk_enable,
   input  logic        load,
   input  logic        inc,
   input  logic [7:0]  page,
   output logic [15:0] src_address,
   output logic [15:0] dst_address,
   output logic        last
);
   logic [CW-1:0] count;
   logic [CW-1:0] idx;
   logic [7:0]    src_page;
   // Addresses are for the count value in effect after this edge, so the top can register them.
   always_comb begin
      idx = inc ? count + CW'(1) : count;
      src_address = {src_page, 8'h00} + 16'(idx);
      dst_address = DST_BASE + 16'(idx);
      last = count == CW'(LENGTH - 1);
   end
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         count <= '0;
         src_page <= '0;
      end else if (cpu_clk_enable) begin
         if (load) begin
            count <= '0;
            src_page <= page;
         end else if (inc) begin
            count <= idx;
         end
      end
   end
endmodule

// File: rtl/vram_dma_m.sv
// vram_dma_m: CPU-triggered RAM-to-VRAM block copy that halts the CPU and owns the bus while copying.
module vram_dma_m import vram_dma_pkg::*; #(
   parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
   parameter logic [15:0] DST_BASE = VRAM_BASE,
   parameter int LENGTH = 256,
   parameter bit WAIT_VBLANK = 1'b1
) (
   input  logic        cpu_clk,
   input  logic        rst,
   input  logic        cpu_clk_enable,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  data_in,
   input  logic        write_enable,
   input  logic [7:0]  bus_data_in,
   input  logic        in_vblank,
   output logic        cpu_rdy,
   output logic        dma_bus_grant,
   output logic [15:0] dma_address,
   output logic [7:0]  dma_data_out,
   output logic        dma_write_enable,
   output logic        dma_busy
);
   dma_state_t  state;
   logic        trigger;
   logic        inc;
   logic        last;
   logic [7:0]  data_latch;
   logic [15:0] src_address;
   logic [15:0] dst_address;
   always_comb begin
      trigger = state == IDLE && write_enable && cpu_address == DMA_REG_ADDR;
      inc = state == WRITE && !last;
   end
   assign dma_data_out = data_latch;
   vram_dma_addr_gen_m #(.DST_BASE(DST_BASE), .LENGTH(LENGTH)) u_addr_gen (
      .cpu_clk(cpu_clk),
      .rst(rst),
      .cpu_clk_enable(cpu_clk_enable),
      .load(trigger),
      .inc(inc),
      .page(data_in),
      .src_address(src_address),
      .dst_address(dst_address),
      .last(last)
   );
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         state <= IDLE;
         cpu_rdy <= 1'b1;
         dma_bus_grant <= 1'b0;
         dma_write_enable <= 1'b0;
         dma_address <= '0;
         data_latch <= '0;
         dma_busy <= 1'b0;
      end else if (cpu_clk_enable) begin
         case (state)
            IDLE: if (trigger) begin
               state <= HALT;
               cpu_rdy <= 1'b0;
               dma_busy <= 1'b1;
            end
            // Grant stays low here so the CPU's trigger write finishes on the bus.
            HALT: if (!WAIT_VBLANK || in_vblank) begin
               state <= READ;
               dma_bus_grant <= 1'b1;
               dma_address <= src_address;
            end
            READ: begin
               state <= WRITE;
               dma_write_enable <= 1'b1;
               data_latch <= bus_data_in;
               dma_address <= dst_address;
            end
            WRITE: begin
               dma_write_enable <= 1'b0;
               if (last) begin
                  state <= IDLE;
                  cpu_rdy <= 1'b1;
                  dma_bus_grant <= 1'b0;
                  dma_busy <= 1'b0;
               end else begin
                  state <= READ;
                  dma_address <= src_address;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vram_dma_m.sv
// tb_vram_dma_m: directed bench for vram_dma_m with a small-copy instance and a vblank-gated full-page instance.
module tb_vram_dma_m;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [15:0] addr = '0;
   logic [7:0]  din = '0;
   logic        we0 = 1'b0;
   logic        we1 = 1'b0;
   logic        vb = 1'b0;
   logic [7:0]  bd0, bd1, d0, d1;
   logic [15:0] a0, a1;
   logic        rdy0, g0, w0, b0, rdy1, g1, w1, b1;
   logic [7:0]  ram [0:65535];
   logic [7:0]  vram0 [0:65535];
   logic [7:0]  vram1 [0:65535];
   int          nwr0 = 0;
   int          nwr1 = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   assign bd0 = ram[a0];
   assign bd1 = ram[a1];

   vram_dma_m #(.LENGTH(4), .WAIT_VBLANK(1'b0)) u0 (
      .cpu_clk(clk), .rst(rst), .cpu_clk_enable(en), .cpu_address(addr), .data_in(din),
      .write_enable(we0), .bus_data_in(bd0), .in_vblank(vb), .cpu_rdy(rdy0), .dma_bus_grant(g0),
      .dma_address(a0), .dma_data_out(d0), .dma_write_enable(w0), .dma_busy(b0));

   vram_dma_m #(.DST_BASE(16'hFF80), .LENGTH(256), .WAIT_VBLANK(1'b1)) u1 (
      .cpu_clk(clk), .rst(rst), .cpu_clk_enable(en), .cpu_address(addr), .data_in(din),
      .write_enable(we1), .bus_data_in(bd1), .in_vblank(vb), .cpu_rdy(rdy1), .dma_bus_grant(g1),
      .dma_address(a1), .dma_data_out(d1), .dma_write_enable(w1), .dma_busy(b1));

   // VRAM side of the bus: a write lands whenever the DMA strobes on an enabled edge.
   always @(posedge clk) begin
      if (en && g0 && w0) begin
         vram0[a0] <= d0;
         nwr0 <= nwr0 + 1;
      end
      if (en && g1 && w1) begin
         vram1[a1] <= d1;
         nwr1 <= nwr1 + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic trig0(input logic [7:0] page);
      addr = 16'h7010;
      din = page;
      we0 = 1'b1;
      tick();
      we0 = 1'b0;
      addr = '0;
   endtask

   task automatic trig1(input logic [7:0] page);
      addr = 16'h7010;
      din = page;
      we1 = 1'b1;
      tick();
      we1 = 1'b0;
      addr = '0;
   endtask

   initial begin
      int n;
      int k;
      int hold_bad;
      int nw;
      logic [27:0] snap;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h0200] = 8'hAA; ram[16'h0201] = 8'hBB; ram[16'h0202] = 8'hCC; ram[16'h0203] = 8'hDD;
      ram[16'h0300] = 8'h11; ram[16'h0301] = 8'h22; ram[16'h0302] = 8'h33; ram[16'h0303] = 8'h44;
      ram[16'h0400] = 8'h01; ram[16'h0401] = 8'h02; ram[16'h0402] = 8'h03; ram[16'h0403] = 8'h04;
      for (int i = 0; i < 256; i++) ram[16'hFF00 + i] = 8'(i) ^ 8'h5A;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_ctl0", {rdy0, g0, w0, b0}, 4'b1000);
      chk("reset_addr0", a0, 16'h0000);
      chk("reset_data0", d0, 8'h00);
      chk("reset_ctl1", {rdy1, g1, w1, b1}, 4'b1000);

      // Wrong register and a CPU read of the trigger address must not start a copy.
      addr = 16'h7011; din = 8'h02; we0 = 1'b1; we1 = 1'b1;
      tick();
      we0 = 1'b0; we1 = 1'b0; addr = 16'h7010;
      tick();
      tick();
      chk("no_trig_ctl0", {rdy0, g0, w0, b0}, 4'b1000);
      chk("no_trig_ctl1", {rdy1, g1, w1, b1}, 4'b1000);
      chk("no_trig_addr0", a0, 16'h0000);

      // Four-byte copy, no vblank wait.
      trig0(8'h02);
      chk("halt_ctl0", {rdy0, g0, w0, b0}, 4'b0001);
      n = 1;
      tick();
      chk("first_read0", {g0, w0, a0}, {2'b10, 16'h0200});
      if (rdy0 === 1'b0) n++;
      k = 0;
      while (rdy0 === 1'b0 && k < 40) begin
         tick();
         if (rdy0 === 1'b0) n++;
         k++;
      end
      chk("rdy_low_cycles", n, 9);
      chk("done_ctl0", {rdy0, g0, w0, b0}, 4'b1000);
      chk("vram0_3700", vram0[16'h3700], 8'hAA);
      chk("vram0_3701", vram0[16'h3701], 8'hBB);
      chk("vram0_3702", vram0[16'h3702], 8'hCC);
      chk("vram0_3703", vram0[16'h3703], 8'hDD);
      chk("writes0_t1", nwr0, 4);

      // Clock enable high one edge in four; disabled edges must change nothing.
      trig0(8'h04);
      hold_bad = 0;
      for (int i = 1; i < 200 && b0 !== 1'b0; i++) begin
         en = (i % 4 == 0);
         snap = {rdy0, g0, w0, b0, a0, d0};
         tick();
         if (!en && snap !== {rdy0, g0, w0, b0, a0, d0}) hold_bad++;
      end
      en = 1'b1;
      chk("gated_hold", hold_bad, 0);
      chk("gated_done0", {rdy0, g0, w0, b0}, 4'b1000);
      chk("gated_3700", vram0[16'h3700], 8'h01);
      chk("gated_3703", vram0[16'h3703], 8'h04);

      // Reset during the WRITE of byte 2 aborts; the next trigger restarts at count 0.
      trig0(8'h02);
      repeat (6) tick();
      chk("w2_bus0", {g0, w0, a0, d0}, {2'b11, 16'h3702, 8'hCC});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ctl0", {rdy0, g0, w0, b0}, 4'b1000);
      chk("abort_addr0", {a0, d0}, 24'h000000);
      nw = nwr0;
      repeat (3) tick();
      chk("abort_no_write", nwr0, nw);
      trig0(8'h03);
      tick();
      chk("restart_read0", {g0, w0, a0}, {2'b10, 16'h0300});
      k = 0;
      while (b0 !== 1'b0 && k < 40) begin
         tick();
         k++;
      end
      chk("restart_3700", vram0[16'h3700], 8'h11);
      chk("restart_3703", vram0[16'h3703], 8'h44);

      // Vblank gating: hold in HALT until in_vblank, then start; falling vblank does not abort.
      trig1(8'h02);
      repeat (5) tick();
      chk("vb_wait_ctl1", {rdy1, g1, w1, b1}, 4'b0001);
      vb = 1'b1;
      tick();
      chk("vb_first_read1", {g1, w1, a1}, {2'b10, 16'h0200});
      vb = 1'b0;
      nw = nwr1;
      k = 0;
      while (b1 !== 1'b0 && k < 600) begin
         tick();
         k++;
      end
      chk("vb_done_ctl1", {rdy1, g1, w1, b1}, 4'b1000);
      chk("vb_writes1", nwr1 - nw, 256);
      chk("vb_ff80", vram1[16'hFF80], 8'hAA);
      chk("vb_ff83", vram1[16'hFF83], 8'hDD);

      // Full page from 0xFF00 with the destination wrapping through 0x0000.
      vb = 1'b1;
      trig1(8'hFF);
      tick();
      chk("wrap_first_read1", {g1, w1, a1}, {2'b10, 16'hFF00});
      nw = nwr1;
      k = 0;
      while (b1 !== 1'b0 && k < 600) begin
         tick();
         k++;
      end
      chk("wrap_writes1", nwr1 - nw, 256);
      chk("wrap_ff80", vram1[16'hFF80], 8'h5A);
      chk("wrap_ffff", vram1[16'hFFFF], 8'h25);
      chk("wrap_0000", vram1[16'h0000], 8'hDA);
      chk("wrap_007f", vram1[16'h007F], 8'hA5);
      chk("wrap_done_ctl1", {rdy1, g1, w1, b1}, 4'b1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
